// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the CPU pipeline-stage buffers.
// Stage-state encoding, datapath field widths and control-bundle bit positions.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int REG_IDX_W = 6;
  localparam int ALUOP_W   = 3;

  // idex/exmem control bundle layout
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_ALUOP_LSB  = 7;
  localparam int CTRL_ALUOP_MSB  = CTRL_ALUOP_LSB + ALUOP_W - 1;

  function automatic logic [1:0] state_occ(input stage_state_e s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready link carrying a datapath payload and its control-bit bundle.
// The master drives valid/data/ctrl; the slave returns ready.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One payload+control register with load enable; kill clears valid/ctrl but keeps data.
// ctrl is forced to zero whenever the slot is loaded without a valid entry.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill_i,
  input  logic              ld_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else if (kill_i) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else if (ld_i) begin
      vld_q  <= vld_i;
      data_q <= data_i;
      ctrl_q <= vld_i ? ctrl_i : '0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: 1-cycle latency, 1 entry/cycle, strict FIFO order.
// SKID=1 gives a 2-entry skid with registered in_ready; SKID=0 a single entry with combinational ready.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter bit SKID   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  pipe_stage_buf_if.slave       up,
  pipe_stage_buf_if.master      dn,
  output logic [1:0]            occupancy
);

  stage_state_e state_q, state_d;
  logic         in_rdy_q;
  logic [1:0]   occ_q;

  logic in_rdy, accept, emit;

  logic              main_vld, main_ld, main_vld_d;
  logic [DATA_W-1:0] main_data, main_data_d;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_d;

  logic              skid_vld, skid_ld, skid_vld_d;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign emit   = main_vld & dn.ready;
  assign accept = up.valid & in_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept && !emit)      state_d = SKID ? ST_SKID : ST_FULL;
        else if (!accept && emit) state_d = ST_EMPTY;
      end
      ST_SKID:  if (emit) state_d = ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    // A flush discards everything, including a same-cycle accept.
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      in_rdy_q <= 1'b1;
      occ_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != ST_SKID);
      occ_q    <= state_occ(state_d);
    end
  end

  // Main refills from the skid entry first, so the older entry always leaves first.
  always_comb begin
    main_ld     = ((state_q == ST_EMPTY) && accept) || emit;
    main_vld_d  = (state_q == ST_SKID) ? skid_vld  : accept;
    main_data_d = (state_q == ST_SKID) ? skid_data : up.data;
    main_ctrl_d = (state_q == ST_SKID) ? skid_ctrl : up.ctrl;
    skid_ld     = ((state_q == ST_FULL) && accept && !emit) ||
                  ((state_q == ST_SKID) && emit);
    skid_vld_d  = (state_q == ST_FULL);
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill_i (flush),
    .ld_i   (main_ld),
    .vld_i  (main_vld_d),
    .data_i (main_data_d),
    .ctrl_i (main_ctrl_d),
    .vld_o  (main_vld),
    .data_o (main_data),
    .ctrl_o (main_ctrl)
  );

  if (SKID) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .kill_i (flush),
      .ld_i   (skid_ld),
      .vld_i  (skid_vld_d),
      .data_i (up.data),
      .ctrl_i (up.ctrl),
      .vld_o  (skid_vld),
      .data_o (skid_data),
      .ctrl_o (skid_ctrl)
    );
    assign in_rdy = in_rdy_q;
  end else begin : g_flat
    assign skid_vld  = 1'b0;
    assign skid_data = '0;
    assign skid_ctrl = '0;
    assign in_rdy    = !main_vld || dn.ready;
  end

  assign up.ready  = in_rdy;
  assign dn.valid  = main_vld;
  assign dn.data   = main_data;
  assign dn.ctrl   = main_ctrl;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a SKID=1 and a SKID=0 stage from shared stimulus; each is scored against a FIFO model.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam int CW = 16;
  typedef logic [DW+CW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [1:0]    occ0, occ1;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up0 ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn0 ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();

  assign up0.valid = in_valid;
  assign up0.data  = in_data;
  assign up0.ctrl  = in_ctrl;
  assign dn0.ready = out_ready;
  assign up1.valid = in_valid;
  assign up1.data  = in_data;
  assign up1.ctrl  = in_ctrl;
  assign dn1.ready = out_ready;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_flat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up0), .dn(dn0), .occupancy(occ0));
  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up1), .dn(dn1), .occupancy(occ1));

  // index 0 = single-entry build, 1 = skid build
  logic          rdy [2];
  logic          vld [2];
  logic [DW-1:0] odat[2];
  logic [CW-1:0] octl[2];
  logic [1:0]    occ [2];
  assign rdy[0] = up0.ready;  assign rdy[1] = up1.ready;
  assign vld[0] = dn0.valid;  assign vld[1] = dn1.valid;
  assign odat[0] = dn0.data;  assign odat[1] = dn1.data;
  assign octl[0] = dn0.ctrl;  assign octl[1] = dn1.ctrl;
  assign occ[0] = occ0;       assign occ[1] = occ1;

  int checks = 0;
  int errors = 0;

  ent_t mq[2][4];
  int   mhead[2] = '{0, 0};
  int   mcnt[2]  = '{0, 0};

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Scoreboard push: every entry the stage takes at this edge becomes an expected output.
  always @(posedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (!rst_n || flush) begin
        mcnt[id]  = 0;
        mhead[id] = 0;
      end else if (in_valid && rdy[id] && mcnt[id] < 4) begin
        mq[id][(mhead[id] + mcnt[id]) % 4] = {in_data, in_ctrl};
        mcnt[id]++;
      end
    end
  end

  // Monitor: compare what each stage presents against the model, pop on emit.
  always @(negedge clk) begin : mon
    logic er;
    ent_t h;
    for (int id = 0; id < 2; id++) begin
      er = (id == 1) ? (mcnt[id] < 2) : (mcnt[id] == 0 || out_ready);
      chk("occupancy", id, 64'(occ[id]), 64'(mcnt[id]));
      chk("out_valid", id, 64'(vld[id]), 64'(mcnt[id] > 0));
      chk("in_ready", id, 64'(rdy[id]), 64'(er));
      if (!vld[id]) begin
        chk("bubble_ctrl", id, 64'(octl[id]), 64'(0));
      end else if (mcnt[id] > 0) begin
        h = mq[id][mhead[id]];
        chk("out_data", id, 64'(odat[id]), 64'(h[DW+CW-1:CW]));
        chk("out_ctrl", id, 64'(octl[id]), 64'(h[CW-1:0]));
        if (out_ready) begin
          mhead[id] = (mhead[id] + 1) % 4;
          mcnt[id]--;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(32'h55, 16'hFFFF);
    cyc(); cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    for (int id = 0; id < 2; id++) chk("reset_data", id, 64'(odat[id]), 64'(0));
    cyc();

    for (int k = 0; k < 8; k++) begin
      offer(32'h100 + 32'(k), 16'($urandom));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();

    // Stall with the skid filling: 0xC must wait for space.
    offer(32'hA, 16'h00A1); cyc();
    out_ready = 1'b0;
    offer(32'hB, 16'h00B2); cyc();
    offer(32'hC, 16'h00C3); repeat (4) cyc();
    @(negedge clk);
    chk("skid_full_occ", 1, 64'(occ[1]), 64'(2));
    out_ready = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    repeat (4) cyc();

    // Flush with two entries held and a new offer in the same cycle.
    out_ready = 1'b0;
    offer(32'h1A, 16'hFFFF); cyc();
    offer(32'h1B, 16'hFFFF); cyc();
    offer(32'hD, 16'hFFFF); flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    // Reset and flush together while the skid is full.
    out_ready = 1'b0;
    offer(32'h2A, 16'h1234); cyc();
    offer(32'h2B, 16'h5678); cyc();
    rst_n = 1'b0; flush = 1'b1; cyc();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int id = 0; id < 2; id++) chk("prio_data", id, 64'(odat[id]), 64'(0));
    cyc();

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    for (int id = 0; id < 2; id++) chk("drained", id, 64'(mcnt[id]), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
